// File: rtl/dm_ctrl.sv
// Data-memory controller for the MEM stage: aligns loads/stores onto a
// word bus, waits for ack with a timeout, and extends load results.
module dm_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic          we_q;
  logic [1:0]    off_q;

  logic        is_w;
  logic        is_h;
  logic        mis;
  logic        idle_req;
  logic        accept;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext;

  // Reserved ops 101-111 fall into the word class via op[2].
  assign is_w = req_op[2];
  assign is_h = !req_op[2] && req_op[1];
  assign mis = (is_w && req_addr[1:0] != 2'b00) ||
               (is_h && req_addr[0]);

  assign idle_req = reset && state == IDLE && req_valid;
  assign accept   = idle_req && !mis;
  assign exc_adel = idle_req && mis && !req_we;
  assign exc_ades = idle_req && mis && req_we;
  assign stall    = accept || (reset && state == ACCESS);

  always_comb begin
    be_n = 4'hF;
    wd_n = req_wdata;
    unique case (1'b1)
      is_w: begin
        be_n = 4'hF;
        wd_n = req_wdata;
      end
      is_h: begin
        be_n = req_addr[1] ? 4'hC : 4'h3;
        wd_n = {2{req_wdata[15:0]}};
      end
      default: begin
        be_n = 4'b0001 << req_addr[1:0];
        wd_n = {4{req_wdata[7:0]}};
      end
    endcase
    if (!req_we)
      be_n = 4'hF;
  end

  always_comb begin
    byte_v = mem_rdata[{off_q, 3'b000} +: 8];
    half_v = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext    = mem_rdata;
    unique case (1'b1)
      op_q[2]:
        ext = mem_rdata;
      !op_q[2] && op_q[1]:
        ext = {{16{half_v[15] & ~op_q[0]}}, half_v};
      default:
        ext = {{24{byte_v[7] & ~op_q[0]}}, byte_v};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      we_q      <= 1'b0;
      off_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      bus_err   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      bus_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= ACCESS;
            cnt       <= '0;
            op_q      <= req_op;
            we_q      <= req_we;
            off_q     <= req_addr[1:0];
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= wd_n;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            rd_valid <= !we_q;
            if (!we_q)
              rd_data <= ext;
          end else if (cnt == CW'(MAX_WAIT - 1)) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            rd_valid <= !we_q;
            bus_err  <= 1'b1;
            rd_data  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
